// File: rtl/snax_gemm_block_sequencer.sv
// snax_gemm_block_sequencer
//
// GEMM accelerator shell with in-shell block sequencing. A CSR launch
// latches an M x K x N job. The A and B streamer channels are joined into
// single beats for an external MAC core. Each beat is tagged with the
// first and last k-step of its output tile. Core results are buffered in
// a small C FIFO toward the output streamer.
//
// Ports:
//   clk_i, rst_i                   clock, asynchronous active-high reset
//   csr_reg_set_*                  job launch: {sub_const, N, K, M}
//   csr_reg_ro_set_o               {stall cycles, busy cycles, busy}
//   stream2acc_0_* / stream2acc_1_* A / B input streams
//   acc2stream_0_*                 C output stream (FIFO head)
//   core_a_o, core_b_o, core_in_*  joined beat toward the MAC core
//   core_k_first_o, core_k_last_o  k-step markers of the current beat
//   core_sub_const_o               latched subtraction constant
//   core_c_*                       result from the MAC core into the FIFO
module snax_gemm_block_sequencer #(
    parameter int DataWidthA   = 512,
    parameter int DataWidthB   = 512,
    parameter int DataWidthC   = 2048,
    parameter int RegDataWidth = 32,
    parameter int DimWidth     = 16,
    parameter int CFifoDepth   = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [4*RegDataWidth-1:0] csr_reg_set_i,
    input  logic                      csr_reg_set_valid_i,
    output logic                      csr_reg_set_ready_o,
    output logic [3*RegDataWidth-1:0] csr_reg_ro_set_o,
    input  logic [DataWidthA-1:0]     stream2acc_0_data_i,
    input  logic                      stream2acc_0_valid_i,
    output logic                      stream2acc_0_ready_o,
    input  logic [DataWidthB-1:0]     stream2acc_1_data_i,
    input  logic                      stream2acc_1_valid_i,
    output logic                      stream2acc_1_ready_o,
    output logic [DataWidthC-1:0]     acc2stream_0_data_o,
    output logic                      acc2stream_0_valid_o,
    input  logic                      acc2stream_0_ready_i,
    output logic [DataWidthA-1:0]     core_a_o,
    output logic [DataWidthB-1:0]     core_b_o,
    output logic                      core_in_valid_o,
    input  logic                      core_in_ready_i,
    output logic                      core_k_first_o,
    output logic                      core_k_last_o,
    output logic [RegDataWidth-1:0]   core_sub_const_o,
    input  logic [DataWidthC-1:0]     core_c_i,
    input  logic                      core_c_valid_i,
    output logic                      core_c_ready_o
);

    localparam int TW = 2 * DimWidth;
    localparam int PW = (CFifoDepth > 1) ? $clog2(CFifoDepth) : 1;
    localparam int CW = $clog2(CFifoDepth + 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                  state_q;
    logic [DimWidth-1:0]     k_q, ki_q;
    logic [TW-1:0]           mn_q, in_tile_q, out_tile_q;
    logic [RegDataWidth-1:0] sub_q, busy_cnt_q, stall_cnt_q;
    logic [PW-1:0]           wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]           cnt_q;
    logic [DataWidthC-1:0]   c_mem [CFifoDepth];

    function automatic logic [RegDataWidth-1:0] sat_inc(input logic [RegDataWidth-1:0] v);
        return (&v) ? v : v + RegDataWidth'(1);
    endfunction

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(CFifoDepth - 1)) ? '0 : p + PW'(1);
    endfunction

    // Launch decode: only the low DimWidth bits of each dimension word count.
    logic [DimWidth-1:0]     m_new, k_new, n_new;
    logic [RegDataWidth-1:0] sub_new;
    logic [TW-1:0]           mn_new;
    logic                    unused_csr_bits;

    assign m_new           = csr_reg_set_i[0*RegDataWidth +: DimWidth];
    assign k_new           = csr_reg_set_i[1*RegDataWidth +: DimWidth];
    assign n_new           = csr_reg_set_i[2*RegDataWidth +: DimWidth];
    assign sub_new         = csr_reg_set_i[3*RegDataWidth +: RegDataWidth];
    assign mn_new          = TW'(m_new) * TW'(n_new);
    assign unused_csr_bits = ^csr_reg_set_i;

    logic launch, in_fire, k_last, fifo_full, push, pop;

    assign launch = csr_reg_set_valid_i & (state_q == IDLE);
    assign k_last = (ki_q == k_q - DimWidth'(1));

    // Join: a beat exists only when both streams offer data, so neither
    // stream can ever be consumed without the other.
    assign core_in_valid_o = (state_q == RUN) & stream2acc_0_valid_i &
                             stream2acc_1_valid_i & (in_tile_q < mn_q);
    assign in_fire              = core_in_valid_o & core_in_ready_i;
    assign stream2acc_0_ready_o = in_fire;
    assign stream2acc_1_ready_o = in_fire;
    assign core_a_o             = stream2acc_0_data_i;
    assign core_b_o             = stream2acc_1_data_i;
    assign core_k_first_o       = (ki_q == '0);
    assign core_k_last_o        = k_last;
    assign core_sub_const_o     = sub_q;

    assign fifo_full            = (cnt_q == CW'(CFifoDepth));
    assign core_c_ready_o       = ~fifo_full & (state_q != IDLE);
    assign push                 = core_c_valid_i & core_c_ready_o;
    assign acc2stream_0_valid_o = (cnt_q != '0);
    assign acc2stream_0_data_o  = c_mem[rd_ptr_q];
    assign pop                  = acc2stream_0_valid_o & acc2stream_0_ready_i;

    assign csr_reg_set_ready_o = (state_q == IDLE);
    assign csr_reg_ro_set_o    = {stall_cnt_q, busy_cnt_q,
                                  {(RegDataWidth-1){1'b0}}, (state_q != IDLE)};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            k_q         <= '0;
            ki_q        <= '0;
            mn_q        <= '0;
            in_tile_q   <= '0;
            out_tile_q  <= '0;
            sub_q       <= '0;
            busy_cnt_q  <= '0;
            stall_cnt_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
        end else begin
            if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop) begin
                rd_ptr_q   <= ptr_inc(rd_ptr_q);
                out_tile_q <= out_tile_q + TW'(1);
            end
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase

            case (state_q)
                IDLE: begin
                    if (launch) begin
                        k_q         <= k_new;
                        mn_q        <= mn_new;
                        sub_q       <= sub_new;
                        ki_q        <= '0;
                        in_tile_q   <= '0;
                        out_tile_q  <= '0;
                        busy_cnt_q  <= '0;
                        stall_cnt_q <= '0;
                        // A zero dimension is an empty job: nothing to issue.
                        if (m_new != '0 && k_new != '0 && n_new != '0) state_q <= RUN;
                    end
                end
                RUN: begin
                    busy_cnt_q <= sat_inc(busy_cnt_q);
                    if (!in_fire) stall_cnt_q <= sat_inc(stall_cnt_q);
                    if (in_fire) begin
                        if (k_last) begin
                            ki_q      <= '0;
                            in_tile_q <= in_tile_q + TW'(1);
                            if (in_tile_q + TW'(1) == mn_q) state_q <= DRAIN;
                        end else begin
                            ki_q <= ki_q + DimWidth'(1);
                        end
                    end
                end
                DRAIN: begin
                    busy_cnt_q <= sat_inc(busy_cnt_q);
                    if (out_tile_q == mn_q) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // FIFO storage carries data only; occupancy lives in the control regs.
    always_ff @(posedge clk_i) begin
        if (push) c_mem[wr_ptr_q] <= core_c_i;
    end

endmodule

// File: tb/tb_snax_gemm_block_sequencer.sv
// Directed bench for snax_gemm_block_sequencer: launches small block-GEMM
// jobs, models the A/B streams and a MAC core that answers one cycle after
// each k_last beat, and checks beats, C order, counters and reset.
module tb_snax_gemm_block_sequencer;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] csr_set;
    logic         csr_valid;
    logic         csr_ready;
    logic [95:0]  ro;
    logic [15:0]  a_data, b_data, core_a, core_b;
    logic         a_valid, a_ready, b_valid, b_ready;
    logic [31:0]  acc_data, core_c, sub_const;
    logic         acc_valid, acc_ready;
    logic         core_in_valid, core_in_ready, k_first, k_last;
    logic         core_c_valid, core_c_ready;

    logic [15:0]  a_idx = 16'd0;
    logic [15:0]  b_idx = 16'd0;
    int           gbeats = 0;
    int           checks = 0;
    int           errors = 0;

    assign a_data = 16'hA000 + a_idx;
    assign b_data = 16'hB000 + b_idx;

    always #5 clk = ~clk;

    snax_gemm_block_sequencer #(
        .DataWidthA(16), .DataWidthB(16), .DataWidthC(32),
        .RegDataWidth(32), .DimWidth(16), .CFifoDepth(2)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .csr_reg_set_i(csr_set), .csr_reg_set_valid_i(csr_valid),
        .csr_reg_set_ready_o(csr_ready), .csr_reg_ro_set_o(ro),
        .stream2acc_0_data_i(a_data), .stream2acc_0_valid_i(a_valid),
        .stream2acc_0_ready_o(a_ready),
        .stream2acc_1_data_i(b_data), .stream2acc_1_valid_i(b_valid),
        .stream2acc_1_ready_o(b_ready),
        .acc2stream_0_data_o(acc_data), .acc2stream_0_valid_o(acc_valid),
        .acc2stream_0_ready_i(acc_ready),
        .core_a_o(core_a), .core_b_o(core_b),
        .core_in_valid_o(core_in_valid), .core_in_ready_i(core_in_ready),
        .core_k_first_o(k_first), .core_k_last_o(k_last),
        .core_sub_const_o(sub_const),
        .core_c_i(core_c), .core_c_valid_i(core_c_valid),
        .core_c_ready_o(core_c_ready)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic launch(input int m, input int k, input int n, input logic [31:0] sc);
        @(negedge clk);
        csr_set   = {sc, 32'(n), 32'(k), 32'(m)};
        csr_valid = 1'b1;
        #1;
        check("csr_rdy_launch", 64'(csr_ready), 64'd1);
        @(negedge clk);
        csr_valid = 1'b0;
    endtask

    // Runs one job from its first RUN cycle. hold_acc stalls the C stream
    // until cycle 8; hold_launch requests a new job during RUN; abort_at >= 0
    // asserts reset in that cycle and returns with rst still high.
    task automatic run_job(input int m, input int k, input int n, input bit b_alt,
                           input bit hold_acc, input bit hold_launch,
                           input int abort_at, input logic [7:0] tag);
        int cyc = 0, beats = 0, c_rcv = 0, c_sent = 0, owed = 0;
        bit lone = 0, done = 0, adv_a, adv_b, push, kl_exp, kf_exp;
        while (!done) begin
            a_valid      = 1'b1;
            b_valid      = b_alt ? (cyc % 2 == 1) : 1'b1;
            acc_ready    = hold_acc ? (cyc >= 8) : 1'b1;
            core_c_valid = (owed > 0);
            core_c       = 32'hC000_0000 | (32'(tag) << 8) | 32'(c_sent);
            if (hold_launch && cyc == 1) begin
                csr_set   = {32'h22, 32'd1, 32'd1, 32'd1};
                csr_valid = 1'b1;
            end
            #1;
            if (cyc == abort_at) begin
                check("fifo_one_before_rst", 64'(acc_valid), 64'd1);
                rst = 1'b1;
                #1;
                check("rst_outputs", 64'({acc_valid, core_in_valid, a_ready, b_ready,
                                          core_c_ready, csr_ready}), 64'b000001);
                check("rst_ro", 64'(ro[63:0]), 64'd0);
                return;
            end
            if (cyc == 0) check("busy_run", 64'(ro[0]), 64'd1);
            if (hold_launch && cyc == 1) check("csr_rdy_run", 64'(csr_ready), 64'd0);
            if (hold_acc && cyc == 7) check("c_ready_full", 64'(core_c_ready), 64'd0);
            if (hold_acc && cyc == 8) check("c_ready_pop_cycle", 64'(core_c_ready), 64'd0);
            if (hold_acc && cyc == 9) check("c_ready_back", 64'(core_c_ready), 64'd1);
            if (a_ready != b_ready || (a_ready && !(a_valid && b_valid))) lone = 1;
            adv_a  = a_ready;
            adv_b  = b_ready;
            push   = core_c_valid && core_c_ready;
            kl_exp = 0;
            if (core_in_valid && core_in_ready) begin
                kf_exp = (beats % k == 0);
                kl_exp = (beats % k == k - 1);
                check("beat", {32'd0, core_a, core_b}, {32'd0, 16'hA000 + 16'(gbeats),
                                                         16'hB000 + 16'(gbeats)});
                check("beat_k_flags", 64'({k_first, k_last}), 64'({kf_exp, kl_exp}));
                beats++;
                gbeats++;
            end
            if (acc_valid && acc_ready) begin
                check("c_data", 64'(acc_data),
                      64'(32'hC000_0000 | (32'(tag) << 8) | 32'(c_rcv)));
                c_rcv++;
            end
            if (push) c_sent++;
            owed = owed + int'(kl_exp) - int'(push);
            if (beats == m * k * n && c_rcv == m * n && ro[0] == 1'b0) begin
                done = 1;
            end else if (cyc >= 200) begin
                check("job_timeout", 64'(cyc), 64'd0);
                done = 1;
            end else begin
                @(negedge clk);
                if (adv_a) a_idx++;
                if (adv_b) b_idx++;
                cyc++;
            end
        end
        check("no_lone_consume", 64'(lone), 64'd0);
    endtask

    initial begin
        rst = 1'b1; csr_set = '0; csr_valid = 1'b0;
        a_valid = 1'b0; b_valid = 1'b0; acc_ready = 1'b0;
        core_in_ready = 1'b1; core_c_valid = 1'b0; core_c = '0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_outputs", 64'({csr_ready, acc_valid, a_ready, b_ready, core_in_valid,
                                    core_c_ready}), 64'b100000);
        check("reset_ro", 64'(ro[63:0]), 64'd0);
        check("reset_sub", 64'(sub_const), 64'd0);
        rst = 1'b0;

        // Basic 2x3x1 job.
        launch(2, 3, 1, 32'h5);
        run_job(2, 3, 1, 0, 0, 0, -1, 8'd1);
        check("t1_busy_cycles", 64'(ro[63:32]), 64'd9);
        check("t1_stall_cycles", 64'(ro[95:64]), 64'd0);
        check("t1_sub_const", 64'(sub_const), 64'h5);

        // B valid on odd cycles only.
        launch(2, 3, 1, 32'h7);
        run_job(2, 3, 1, 1, 0, 0, -1, 8'd2);
        check("t2_busy_cycles", 64'(ro[63:32]), 64'd15);
        check("t2_stall_cycles", 64'(ro[95:64]), 64'd6);

        // C backpressure with a 2-entry FIFO.
        launch(4, 1, 1, 32'h0);
        run_job(4, 1, 1, 0, 1, 0, -1, 8'd3);
        check("t3_busy_cycles", 64'(ro[63:32]), 64'd13);
        check("t3_stall_cycles", 64'(ro[95:64]), 64'd0);

        // K = 0 is an empty job.
        launch(2, 0, 1, 32'h9);
        for (int i = 0; i < 4; i++) begin
            a_valid = 1'b1; b_valid = 1'b1;
            #1;
            check("k0_idle", 64'({a_ready, b_ready, core_in_valid, ro[0], csr_ready}),
                  64'b00001);
            @(negedge clk);
        end
        check("k0_ro", 64'(ro[95:32]), 64'd0);

        // Launch request held during RUN, accepted once back in IDLE.
        launch(1, 2, 1, 32'h11);
        run_job(1, 2, 1, 0, 0, 1, -1, 8'd5);
        check("held_csr_rdy_idle", 64'(csr_ready), 64'd1);
        check("held_old_sub", 64'(sub_const), 64'h11);
        @(negedge clk);
        csr_valid = 1'b0;
        #1;
        check("held_new_sub", 64'(sub_const), 64'h22);
        check("held_busy", 64'(ro[0]), 64'd1);
        run_job(1, 1, 1, 0, 0, 0, -1, 8'd6);
        check("t5_busy_cycles", 64'(ro[63:32]), 64'd4);

        // Reset mid-job with one C entry buffered, then a clean job.
        launch(2, 2, 1, 32'h3);
        run_job(2, 2, 1, 0, 1, 0, 3, 8'd7);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_sub", 64'(sub_const), 64'd0);
        check("post_rst_fifo_empty", 64'(acc_valid), 64'd0);
        launch(2, 3, 1, 32'h5);
        run_job(2, 3, 1, 0, 0, 0, -1, 8'd8);
        check("t6_busy_cycles", 64'(ro[63:32]), 64'd9);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/snax_gemm_block_sequencer.md
Name: snax_gemm_block_sequencer

Overview:
- Parametrised successor of the SNAX GEMM accelerator shell. Adds in-shell sequencing instead of delegating all control to the compute core.
- Accepts an M×K×N block-GEMM job over the CSR set handshake. Joins the A and B streamer channels into single beats for an external MAC core and marks the first and last k-step of each output tile.
- Buffers core results in a parametrised C FIFO toward the streamer.
- Reports busy, busy-cycle count and input-stall count as read-only CSRs.

Parameters:
DataWidthA, 512, A stream beat width
DataWidthB, 512, B stream beat width
DataWidthC, 2048, C result beat width
RegDataWidth, 32, CSR word width
DimWidth, 16, low bits of each M/K/N CSR used; internal counters are 2*DimWidth (tiles) and DimWidth (k)
CFifoDepth, 2, C output FIFO entries (>=1)

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous, active-high reset
csr_reg_set_i  in  4*RegDataWidth  [0]=M, [1]=K, [2]=N, [3]=subtraction constant
csr_reg_set_valid_i  in  1  job launch request
csr_reg_set_ready_o  out  1  high only in IDLE
csr_reg_ro_set_o  out  3*RegDataWidth  [0]=busy (bit0), [1]=busy cycles, [2]=stall cycles
stream2acc_0_data_i / _valid_i / _ready_o  in/in/out  DataWidthA/1/1  A stream
stream2acc_1_data_i / _valid_i / _ready_o  in/in/out  DataWidthB/1/1  B stream
acc2stream_0_data_o / _valid_o / _ready_i  out/out/in  DataWidthC/1/1  C stream
core_a_o  out  DataWidthA  A beat to core
core_b_o  out  DataWidthB  B beat to core
core_in_valid_o  out  1  joined beat valid
core_in_ready_i  in  1  core accepts beat
core_k_first_o  out  1  beat is k==0 of its tile (clear accumulator)
core_k_last_o  out  1  beat is k==K-1 (core must emit one C)
core_sub_const_o  out  RegDataWidth  latched subtraction constant
core_c_i  in  DataWidthC  core result
core_c_valid_i  in  1  core result valid
core_c_ready_o  out  1  FIFO not full and state!=IDLE

Behaviour:
- Reset (async, rst_i=1): state IDLE; all counters 0; FIFO empty; latched M/K/N/sub-const 0.
  - Outputs during reset: csr_reg_set_ready_o=1, all valids/readies 0, ro regs 0.
  - Reset mid-job aborts immediately and discards FIFO contents.
- States:
  - IDLE: launch occurs on csr_reg_set_valid_i & ready.
    - Latch M,K,N (low DimWidth bits) and sub-const.
    - Clear busy/stall counters, tile counters and ki.
    - If any of M,K,N == 0: stay IDLE with counters cleared; no beats, no C.
    - Otherwise go to RUN next cycle.
  - RUN: input issue.
    - Input fire = A.valid & B.valid & core_in_ready_i & (in_tile < M*N).
    - core_in_valid_o = A.valid & B.valid & (in_tile < M*N).
    - stream2acc_0_ready_o = stream2acc_1_ready_o = input fire. Neither stream is consumed alone.
    - core_a_o and core_b_o are the stream data passed through combinationally.
    - On each fire: ki increments. When ki==K-1, ki wraps to 0 and in_tile increments.
    - core_k_first_o = (ki==0); core_k_last_o = (ki==K-1). K==1 asserts both.
    - When in_tile reaches M*N, go to DRAIN.
  - DRAIN: no input readies. Wait until out_tile == M*N, then go to IDLE.
- C path:
  - FIFO push on core_c_valid_i & core_c_ready_o.
  - acc2stream_0_valid_o = FIFO non-empty; pop on valid & ready.
  - Minimum latency core→C output is 1 cycle (registered FIFO).
  - Simultaneous push and pop when full is not allowed: ready is low when full. Pop when full frees space next cycle.
  - Simultaneous push and pop when non-full keeps occupancy.
  - out_tile increments per C pop.
  - C outputs arrive in RUN as well as DRAIN.
- Counters:
  - Busy cycles increment every cycle in RUN or DRAIN and saturate at all-ones.
  - Stall cycles increment in RUN on cycles with no input fire; they saturate.
  - Both hold after the job until the next launch.
- Products M*N use 2*DimWidth bits; no overflow is possible.
- busy = (state != IDLE).

Test Plan:
- M=2,K=3,N=1, A/B always valid, core ready, core returns C one cycle after k_last →
  - 6 joined beats with k_first on beats 0 and 3 and k_last on beats 2 and 5;
  - 2 C beats out; IDLE afterwards;
  - busy reg 1→0; busy cycles = 8 ± FIFO latency (exact value checked against model).
- Same job with B valid low on alternate cycles → A never consumed without B; stall count = 6; data order preserved.
- CFifoDepth=2, acc2stream ready low, M=4,K=1,N=1 →
  - core_c_ready_o drops after 2 pushes;
  - no loss; ready restored the cycle after the first pop; 4 C beats delivered in order.
- Launch with K=0 → no stream readies, busy never 1, ro counters 0, csr ready stays 1.
- Launch attempt during RUN → csr_reg_set_ready_o=0; the request is held and accepted the cycle after return to IDLE, with new sub-const visible on core_sub_const_o.
- Assert rst_i during RUN with 1 FIFO entry → same-cycle outputs to reset values; FIFO empty; next job runs clean.
